// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : wb_arbiter
//  Purpose  : Write-back arbiter for the single integer register-file write
//             port. The in-order ALU/CSR/BJP path competes with two
//             long-latency producers (LSU load return, mul/div), each of
//             which owns a one-entry holding buffer. A fixed-priority
//             arbiter (mem > muldiv > ALU) with a starvation guard for the
//             ALU picks one writer per cycle; the winner is written through
//             a registered port. A pending-register mask lets decode stall
//             on hazards against results that are buffered but unwritten.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, rst_n                 core clock, async active-low reset
//    alu_valid_i/waddr_i/wdata_i   ALU-path result (no buffer, held upstream)
//    alu_ready_o                ALU result consumed this cycle (= grant)
//    mem_valid_i/waddr_i/wdata_i   load return into the mem holding buffer
//    mem_ready_o                mem buffer can accept this cycle
//    muldiv_valid_i/waddr_i/wdata_i mul/div result into the md holding buffer
//    muldiv_ready_o             md buffer can accept this cycle
//    reg_we_o/waddr_o/wdata_o   registered regfile write port
//    pend_mask_o                one-hot OR of buffered destinations (no x0)
//    busy_o                     at least one holding buffer is full
// ============================================================================
module wb_arbiter #(
  parameter int STARVE_MAX = 4   // denied ALU cycles before a forced grant, 1..15
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        alu_valid_i,
  input  logic [4:0]  alu_waddr_i,
  input  logic [31:0] alu_wdata_i,
  output logic        alu_ready_o,

  input  logic        mem_valid_i,
  input  logic [4:0]  mem_waddr_i,
  input  logic [31:0] mem_wdata_i,
  output logic        mem_ready_o,

  input  logic        muldiv_valid_i,
  input  logic [4:0]  muldiv_waddr_i,
  input  logic [31:0] muldiv_wdata_i,
  output logic        muldiv_ready_o,

  output logic        reg_we_o,
  output logic [4:0]  reg_waddr_o,
  output logic [31:0] reg_wdata_o,

  output logic [31:0] pend_mask_o,
  output logic        busy_o
);

  localparam logic [3:0] c_starve_max = 4'(STARVE_MAX);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic        r_mem_full;
  logic [4:0]  r_mem_waddr;
  logic [31:0] r_mem_wdata;

  logic        r_md_full;
  logic [4:0]  r_md_waddr;
  logic [31:0] r_md_wdata;

  logic [3:0]  r_starve_cnt;

  logic        r_reg_we;
  logic [4:0]  r_reg_waddr;
  logic [31:0] r_reg_wdata;

  // --------------------------------------------------------------------------
  // Combinational arbitration
  // --------------------------------------------------------------------------
  logic        w_force_alu;
  logic        w_grant_mem;
  logic        w_grant_md;
  logic        w_grant_alu;
  logic        w_any_grant;
  logic [4:0]  w_win_waddr;
  logic [31:0] w_win_wdata;
  logic        w_mem_ready;
  logic        w_md_ready;
  logic [3:0]  w_starve_nxt;
  logic [31:0] w_pend_mask;

  // Once the ALU has been denied STARVE_MAX times in a row it takes the port
  // regardless of buffered results. Grants look only at buffer state and the
  // ALU request, never at mem/muldiv valid, so ready cannot loop back.
  assign w_force_alu = alu_valid_i && (r_starve_cnt == c_starve_max);

  always_comb begin
    w_grant_mem = 1'b0;
    w_grant_md  = 1'b0;
    w_grant_alu = 1'b0;
    if (w_force_alu) begin
      w_grant_alu = 1'b1;
    end else if (r_mem_full) begin
      w_grant_mem = 1'b1;
    end else if (r_md_full) begin
      w_grant_md = 1'b1;
    end else if (alu_valid_i) begin
      w_grant_alu = 1'b1;
    end
  end

  assign w_any_grant = w_grant_mem | w_grant_md | w_grant_alu;

  // Winner's write fields; only meaningful when w_any_grant is set.
  always_comb begin
    w_win_waddr = 5'd0;
    w_win_wdata = 32'd0;
    if (w_grant_mem) begin
      w_win_waddr = r_mem_waddr;
      w_win_wdata = r_mem_wdata;
    end else if (w_grant_md) begin
      w_win_waddr = r_md_waddr;
      w_win_wdata = r_md_wdata;
    end else if (w_grant_alu) begin
      w_win_waddr = alu_waddr_i;
      w_win_wdata = alu_wdata_i;
    end
  end

  // A buffer being drained this cycle can be refilled on the same edge, so a
  // winning source keeps a throughput of one result per cycle.
  assign w_mem_ready = ~r_mem_full | w_grant_mem;
  assign w_md_ready  = ~r_md_full  | w_grant_md;

  // Counter only runs while an ALU request is actually waiting; it clears as
  // soon as the ALU wins or withdraws.
  always_comb begin
    w_starve_nxt = 4'd0;
    if (alu_valid_i && !w_grant_alu) begin
      if (r_starve_cnt == c_starve_max) begin
        w_starve_nxt = r_starve_cnt;
      end else begin
        w_starve_nxt = r_starve_cnt + 4'd1;
      end
    end
  end

  // x0 is never a real hazard, so its bit is cleared after the OR.
  always_comb begin
    w_pend_mask = 32'd0;
    if (r_mem_full) begin
      w_pend_mask[r_mem_waddr] = 1'b1;
    end
    if (r_md_full) begin
      w_pend_mask[r_md_waddr] = 1'b1;
    end
    w_pend_mask[0] = 1'b0;
  end

  // --------------------------------------------------------------------------
  // Holding buffers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_full  <= 1'b0;
      r_mem_waddr <= 5'd0;
      r_mem_wdata <= 32'd0;
    end else if (mem_valid_i && w_mem_ready) begin
      r_mem_full  <= 1'b1;
      r_mem_waddr <= mem_waddr_i;
      r_mem_wdata <= mem_wdata_i;
    end else if (w_grant_mem) begin
      r_mem_full  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_md_full  <= 1'b0;
      r_md_waddr <= 5'd0;
      r_md_wdata <= 32'd0;
    end else if (muldiv_valid_i && w_md_ready) begin
      r_md_full  <= 1'b1;
      r_md_waddr <= muldiv_waddr_i;
      r_md_wdata <= muldiv_wdata_i;
    end else if (w_grant_md) begin
      r_md_full  <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Starvation counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve_cnt <= 4'd0;
    end else begin
      r_starve_cnt <= w_starve_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Registered write port. A granted x0 result still updates the address and
  // data fields but never raises the write enable. Without a grant the fields
  // hold so the port does not toggle needlessly.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_reg_we    <= 1'b0;
      r_reg_waddr <= 5'd0;
      r_reg_wdata <= 32'd0;
    end else if (w_any_grant) begin
      r_reg_we    <= (w_win_waddr != 5'd0);
      r_reg_waddr <= w_win_waddr;
      r_reg_wdata <= w_win_wdata;
    end else begin
      r_reg_we    <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign alu_ready_o    = w_grant_alu;
  assign mem_ready_o    = w_mem_ready;
  assign muldiv_ready_o = w_md_ready;
  assign reg_we_o       = r_reg_we;
  assign reg_waddr_o    = r_reg_waddr;
  assign reg_wdata_o    = r_reg_wdata;
  assign pend_mask_o    = w_pend_mask;
  assign busy_o         = r_mem_full | r_md_full;

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_arbiter
//  Purpose  : Self-checking bench for wb_arbiter. Directed vector table,
//             starvation and asynchronous-reset sequences, then randomized
//             traffic against a queue-based reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_wb_arbiter;

  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid_i, mem_valid_i, muldiv_valid_i;
  logic [4:0]  alu_waddr_i, mem_waddr_i, muldiv_waddr_i;
  logic [31:0] alu_wdata_i, mem_wdata_i, muldiv_wdata_i;
  logic        alu_ready_o, mem_ready_o, muldiv_ready_o;
  logic        reg_we_o;
  logic [4:0]  reg_waddr_o;
  logic [31:0] reg_wdata_o;
  logic [31:0] pend_mask_o;
  logic        busy_o;

  always #5 clk = ~clk;

  wb_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .alu_valid_i    (alu_valid_i),
    .alu_waddr_i    (alu_waddr_i),
    .alu_wdata_i    (alu_wdata_i),
    .alu_ready_o    (alu_ready_o),
    .mem_valid_i    (mem_valid_i),
    .mem_waddr_i    (mem_waddr_i),
    .mem_wdata_i    (mem_wdata_i),
    .mem_ready_o    (mem_ready_o),
    .muldiv_valid_i (muldiv_valid_i),
    .muldiv_waddr_i (muldiv_waddr_i),
    .muldiv_wdata_i (muldiv_wdata_i),
    .muldiv_ready_o (muldiv_ready_o),
    .reg_we_o       (reg_we_o),
    .reg_waddr_o    (reg_waddr_o),
    .reg_wdata_o    (reg_wdata_o),
    .pend_mask_o    (pend_mask_o),
    .busy_o         (busy_o)
  );

  // One cycle of stimulus plus what must be observed: ready/pend/busy during
  // the cycle, and the write port after the following edge.
  typedef struct {
    logic        av;  logic [4:0] aa;  logic [31:0] ad;
    logic        mv;  logic [4:0] ma;  logic [31:0] mdat;
    logic        dv;  logic [4:0] da;  logic [31:0] ddat;
    logic        ar;  logic       mr;  logic        dr;
    logic [31:0] pend; logic      busy;
    logic        we;  logic [4:0] wa;  logic [31:0] wd;
  } vec_t;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: each holding buffer is a queue of depth <= 1.
  ent_t        q_mem[$];
  ent_t        q_md[$];
  int          m_denied;
  logic        m_we;
  logic [4:0]  m_wa;
  logic [31:0] m_wd;

  vec_t tbl[12];
  vec_t v;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(
    input logic av, input logic [4:0] aa, input logic [31:0] ad,
    input logic mv, input logic [4:0] ma, input logic [31:0] mdat,
    input logic dv, input logic [4:0] da, input logic [31:0] ddat,
    input logic ar, input logic mr, input logic dr,
    input logic [31:0] pend, input logic busy,
    input logic we, input logic [4:0] wa, input logic [31:0] wd);
    vec_t r;
    r.av = av; r.aa = aa; r.ad = ad;
    r.mv = mv; r.ma = ma; r.mdat = mdat;
    r.dv = dv; r.da = da; r.ddat = ddat;
    r.ar = ar; r.mr = mr; r.dr = dr;
    r.pend = pend; r.busy = busy;
    r.we = we; r.wa = wa; r.wd = wd;
    return r;
  endfunction

  function automatic void model_reset();
    q_mem.delete();
    q_md.delete();
    m_denied = 0;
    m_we = 1'b0;
    m_wa = 5'd0;
    m_wd = 32'd0;
  endfunction

  // Fills in the expected fields of a stimulus record and advances the model
  // by one clock.
  function automatic vec_t model_eval(input vec_t vi);
    vec_t r;
    int   win;  // 0 none, 1 mem, 2 muldiv, 3 alu
    ent_t e;
    r = vi;
    if (vi.av && m_denied == STARVE_MAX) win = 3;
    else if (q_mem.size() != 0)          win = 1;
    else if (q_md.size() != 0)           win = 2;
    else if (vi.av)                      win = 3;
    else                                 win = 0;

    r.ar = (win == 3);
    r.mr = (q_mem.size() == 0) || (win == 1);
    r.dr = (q_md.size() == 0) || (win == 2);
    r.pend = 32'd0;
    if (q_mem.size() != 0) r.pend[q_mem[0].a] = 1'b1;
    if (q_md.size() != 0)  r.pend[q_md[0].a] = 1'b1;
    r.pend[0] = 1'b0;
    r.busy = (q_mem.size() != 0) || (q_md.size() != 0);

    if (win == 1) begin
      e = q_mem.pop_front();
      m_wa = e.a; m_wd = e.d;
    end else if (win == 2) begin
      e = q_md.pop_front();
      m_wa = e.a; m_wd = e.d;
    end else if (win == 3) begin
      m_wa = vi.aa; m_wd = vi.ad;
    end
    m_we = (win != 0) && (m_wa != 5'd0);

    if (vi.mv && r.mr) begin e.a = vi.ma; e.d = vi.mdat; q_mem.push_back(e); end
    if (vi.dv && r.dr) begin e.a = vi.da; e.d = vi.ddat; q_md.push_back(e); end

    if (vi.av && win != 3) m_denied = (m_denied < STARVE_MAX) ? m_denied + 1 : STARVE_MAX;
    else                   m_denied = 0;

    r.we = m_we; r.wa = m_wa; r.wd = m_wd;
    return r;
  endfunction

  // Called at posedge+1; returns at the next posedge+1.
  task automatic apply(input vec_t x, input string tag);
    alu_valid_i    = x.av; alu_waddr_i    = x.aa; alu_wdata_i    = x.ad;
    mem_valid_i    = x.mv; mem_waddr_i    = x.ma; mem_wdata_i    = x.mdat;
    muldiv_valid_i = x.dv; muldiv_waddr_i = x.da; muldiv_wdata_i = x.ddat;
    #3;
    check({tag, ".alu_ready"}, 32'(alu_ready_o),    32'(x.ar));
    check({tag, ".mem_ready"}, 32'(mem_ready_o),    32'(x.mr));
    check({tag, ".md_ready"},  32'(muldiv_ready_o), 32'(x.dr));
    check({tag, ".pend_mask"}, pend_mask_o,         x.pend);
    check({tag, ".busy"},      32'(busy_o),         32'(x.busy));
    @(posedge clk);
    #1;
    check({tag, ".reg_we"},    32'(reg_we_o),       32'(x.we));
    check({tag, ".reg_waddr"}, 32'(reg_waddr_o),    32'(x.wa));
    check({tag, ".reg_wdata"}, reg_wdata_o,         x.wd);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    alu_valid_i = 1'b0; mem_valid_i = 1'b0; muldiv_valid_i = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    logic        ar_pat[7];
    logic        mr_pat[7];
    logic        alu_hold;
    logic [4:0]  alu_a;
    logic [31:0] alu_d;

    rst_n = 1'b0;
    alu_valid_i = 1'b0; alu_waddr_i = 5'd0; alu_wdata_i = 32'd0;
    mem_valid_i = 1'b0; mem_waddr_i = 5'd0; mem_wdata_i = 32'd0;
    muldiv_valid_i = 1'b0; muldiv_waddr_i = 5'd0; muldiv_wdata_i = 32'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // ---------------- Directed table -----------------------------------
    //           av aa     ad             mv ma     mdat           dv da      ddat          ar mr dr pend         busy we wa      wd
    tbl[0]  = mk(0, 5'd0, 32'h0,         0, 5'd0, 32'h0,         0, 5'd0,  32'h0,        0, 1, 1, 32'h0,      0,   0, 5'd0,  32'h0);
    tbl[1]  = mk(1, 5'd5, 32'h0000_1234, 0, 5'd0, 32'h0,         0, 5'd0,  32'h0,        1, 1, 1, 32'h0,      0,   1, 5'd5,  32'h0000_1234);
    tbl[2]  = mk(1, 5'd3, 32'h0000_0003, 1, 5'd7, 32'hAAAA_0001, 0, 5'd0,  32'h0,        1, 1, 1, 32'h0,      0,   1, 5'd3,  32'h0000_0003);
    tbl[3]  = mk(1, 5'd4, 32'h0000_0044, 0, 5'd0, 32'h0,         0, 5'd0,  32'h0,        0, 1, 1, 32'h80,     1,   1, 5'd7,  32'hAAAA_0001);
    tbl[4]  = mk(1, 5'd4, 32'h0000_0044, 0, 5'd0, 32'h0,         0, 5'd0,  32'h0,        1, 1, 1, 32'h0,      0,   1, 5'd4,  32'h0000_0044);
    tbl[5]  = mk(0, 5'd0, 32'h0,         0, 5'd0, 32'h0,         1, 5'd0,  32'h0000_DEAD, 0, 1, 1, 32'h0,     0,   0, 5'd4,  32'h0000_0044);
    tbl[6]  = mk(0, 5'd0, 32'h0,         0, 5'd0, 32'h0,         0, 5'd0,  32'h0,        0, 1, 1, 32'h0,      1,   0, 5'd0,  32'h0000_DEAD);
    tbl[7]  = mk(0, 5'd0, 32'h0,         0, 5'd0, 32'h0,         0, 5'd0,  32'h0,        0, 1, 1, 32'h0,      0,   0, 5'd0,  32'h0000_DEAD);
    tbl[8]  = mk(0, 5'd0, 32'h0,         1, 5'd9, 32'h0000_0099, 1, 5'd10, 32'h0000_00A0, 0, 1, 1, 32'h0,     0,   0, 5'd0,  32'h0000_DEAD);
    tbl[9]  = mk(0, 5'd0, 32'h0,         0, 5'd0, 32'h0,         0, 5'd0,  32'h0,        0, 1, 0, 32'h600,    1,   1, 5'd9,  32'h0000_0099);
    tbl[10] = mk(0, 5'd0, 32'h0,         0, 5'd0, 32'h0,         0, 5'd0,  32'h0,        0, 1, 1, 32'h400,    1,   1, 5'd10, 32'h0000_00A0);
    tbl[11] = mk(0, 5'd0, 32'h0,         0, 5'd0, 32'h0,         0, 5'd0,  32'h0,        0, 1, 1, 32'h0,      0,   0, 5'd10, 32'h0000_00A0);
    for (int i = 0; i < 12; i++) begin
      apply(tbl[i], $sformatf("tbl%0d", i));
    end

    // ---------------- Starvation: mem/muldiv stream, ALU held ----------
    do_reset();
    ar_pat = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    mr_pat = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    begin
      int mem_sent = 0;
      int md_sent  = 0;
      int alu_n    = 0;
      for (int c = 0; c < 7; c++) begin
        v = mk(1, 5'(1 + alu_n), 32'hC000_0000 + 32'(alu_n),
               1, 5'd12, 32'hB000_0000 + 32'(mem_sent),
               1, 5'd13, 32'hD000_0000 + 32'(md_sent),
               0, 0, 0, 32'h0, 0, 0, 5'd0, 32'h0);
        v = model_eval(v);
        v.ar = ar_pat[c];
        v.mr = mr_pat[c];
        apply(v, $sformatf("starve%0d", c));
        if (v.ar) alu_n++;
        if (v.mr) mem_sent++;
        if (v.dr) md_sent++;
      end
      // The entry displaced by the forced ALU grant (captured in cycle 4)
      // is the one written after cycle 6.
      check("starve.displaced_addr", 32'(reg_waddr_o), 32'd12);
      check("starve.displaced_data", reg_wdata_o, 32'hB000_0004);
    end

    // ---------------- Asynchronous reset with both buffers full ---------
    do_reset();
    v = mk(1, 5'd3, 32'h0000_0033, 1, 5'd9, 32'h0000_0999, 1, 5'd10, 32'h0000_0AAA,
           0, 0, 0, 32'h0, 0, 0, 5'd0, 32'h0);
    v = model_eval(v);
    apply(v, "rst_fill");
    alu_valid_i = 1'b0; mem_valid_i = 1'b0; muldiv_valid_i = 1'b0;
    #1;
    check("rst.pre_pend", pend_mask_o, 32'h0000_0600);
    check("rst.pre_busy", 32'(busy_o), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst.pend", pend_mask_o, 32'h0);
    check("rst.busy", 32'(busy_o), 32'd0);
    check("rst.we",   32'(reg_we_o), 32'd0);
    check("rst.waddr", 32'(reg_waddr_o), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    for (int c = 0; c < 4; c++) begin
      v = mk(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0,
             0, 0, 0, 32'h0, 0, 0, 5'd0, 32'h0);
      v = model_eval(v);
      apply(v, $sformatf("rst_idle%0d", c));
    end

    // ---------------- Randomized traffic vs model ----------------------
    do_reset();
    alu_hold = 1'b0;
    alu_a = 5'd0;
    alu_d = 32'd0;
    for (int c = 0; c < 400; c++) begin
      logic [4:0] ma, da;
      if (!alu_hold) begin
        alu_hold = ($urandom_range(0, 2) != 0);
        alu_a = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        alu_d = $urandom;
      end
      ma = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      da = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      v = mk(alu_hold, alu_a, alu_d,
             ($urandom_range(0, 2) != 0), ma, $urandom,
             ($urandom_range(0, 2) != 0), da, $urandom,
             0, 0, 0, 32'h0, 0, 0, 5'd0, 32'h0);
      v = model_eval(v);
      apply(v, $sformatf("rnd%0d", c));
      if (v.ar) alu_hold = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
Sequences the single integer register-file write port between the in-order ALU/CSR/BJP result path and the two long-latency producers (LSU load return and mul/div unit). Each long-latency source gets a one-entry holding buffer. A fixed-priority arbiter with a starvation guard chooses one writer per cycle and drives a registered write port into the regfile. A pending-register mask is exported so decode can stall on RAW/WAW hazards against results that have been produced but not yet written.

Parameters:
STARVE_MAX, 4, consecutive denied cycles of a valid ALU request after which the ALU is forced to win the next arbitration (range 1..15).

Ports:
clk  input  1  core clock
rst_n  input  1  reset, asynchronous assert, active-low
alu_valid_i  input  1  ALU-path result valid this cycle
alu_waddr_i  input  5  ALU-path destination register
alu_wdata_i  input  32  ALU-path result
alu_ready_o  output  1  ALU result consumed this cycle (combinational grant)
mem_valid_i  input  1  load result valid
mem_waddr_i  input  5  load destination register
mem_wdata_i  input  32  load data
mem_ready_o  output  1  mem buffer can accept this cycle
muldiv_valid_i  input  1  mul/div result valid
muldiv_waddr_i  input  5  mul/div destination register
muldiv_wdata_i  input  32  mul/div result
muldiv_ready_o  output  1  muldiv buffer can accept this cycle
reg_we_o  output  1  regfile write enable (registered)
reg_waddr_o  output  5  regfile write address (registered)
reg_wdata_o  output  32  regfile write data (registered)
pend_mask_o  output  32  bit n set while a full buffer holds a result for xn (bit 0 always 0)
busy_o  output  1  either holding buffer full

Behaviour:
- Reset (rst_n low, asynchronous): both buffers empty, starvation counter 0, reg_we_o=0, reg_waddr_o=0, reg_wdata_o=0, pend_mask_o=0, busy_o=0. Reset asserted mid-operation discards buffered results; no write is issued for them.
- Buffers: mem_buf and md_buf each hold {full, waddr, wdata}. A transfer occurs on a clock edge where valid_i & ready_o. Captured data is visible to arbitration from the next cycle.
- ready rule: mem_ready_o = ~mem_buf.full | grant_mem. muldiv_ready_o = ~md_buf.full | grant_md. This gives drain-and-refill in the same cycle, so each source sustains 1 result/cycle when it wins. Grants never depend on mem_valid_i or muldiv_valid_i, so there is no combinational loop.
- Arbitration each cycle, over candidates {mem_buf.full, md_buf.full, alu_valid_i}:
  - Normal priority: mem_buf > md_buf > ALU.
  - Forced: if starve_cnt == STARVE_MAX and alu_valid_i, the ALU wins regardless.
  - Exactly one grant or none.
- alu_ready_o = grant_alu. The ALU path has no buffer; the upstream stage holds its result while alu_ready_o=0.
- Starvation counter:
  - Increments when alu_valid_i & ~grant_alu.
  - Clears on grant_alu or when ~alu_valid_i.
  - Saturates at STARVE_MAX.
- Output register, 1-cycle latency: on the edge after a grant, reg_waddr_o and reg_wdata_o take the winner's fields. reg_we_o = 1 iff the winner's waddr != 0. With no grant, reg_we_o=0 and waddr/wdata hold their previous values.
- x0 destination: the result is consumed (buffer freed / alu_ready_o=1) but no write is issued.
- Simultaneous arrival with empty buffers: ALU is granted that cycle, and mem/muldiv are captured into their buffers. Buffered entries win from the next cycle.
- pend_mask_o: OR over full buffers of one-hot(waddr), bit 0 forced 0. It is combinational from buffer state, so it deasserts in the cycle after the buffer drains.
- Ordering contract: upstream must not issue an ALU write to xn while pend_mask_o[n]=1. The arbiter does not detect or resolve same-address races.
- busy_o = mem_buf.full | md_buf.full.

Test Plan:
1. Reset, then idle -> reg_we_o=0, mem_ready_o=1, muldiv_ready_o=1, pend_mask_o=0, alu_ready_o=0.
2. alu_valid_i=1, waddr=5, wdata=0x0000_1234 for one cycle -> alu_ready_o=1 that cycle; next cycle reg_we_o=1, reg_waddr_o=5, reg_wdata_o=0x1234.
3. Cycle 0: mem (x7=0xAAAA_0001) and ALU (x3=0x0000_0003) valid together -> cycle 0 ALU granted, mem captured. Cycle 1: pend_mask_o=0x80, mem granted, and a new ALU request gets alu_ready_o=0. Outputs: cycle 1 writes x3, cycle 2 writes x7. The ALU request is granted in cycle 2.
4. Starvation, STARVE_MAX=4: mem and muldiv deliver back-to-back every cycle with alu_valid_i held high -> ALU denied 4 cycles, granted on the 5th; the buffer it displaced is granted the following cycle with no result lost.
5. muldiv result to x0 -> muldiv_ready_o reasserts/buffer drains, reg_we_o stays 0, pend_mask_o stays 0.
6. Both buffers full (x9, x10), rst_n pulsed low asynchronously mid-cycle -> immediately pend_mask_o=0, busy_o=0, reg_we_o=0; no write to x9 or x10 after release.
